// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: load/count controls in,
// registered count and range/event flags out.
interface param_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic             en;
   logic             up_and_down;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             at_max;
   logic             at_min;
   logic             wrap;
   logic             sat;

   modport master (
      output load, en, up_and_down, d,
      input  q, at_max, at_min, wrap, sat
   );

   modport slave (
      input  load, en, up_and_down, d,
      output q, at_max, at_min, wrap, sat
   );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down counter over 0..MODULUS-1 with clamped parallel load, wrap or
// saturate at the range ends, and registered one-cycle wrap/sat event flags.
module param_updown_counter #(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter bit              SATURATE = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   param_updown_counter_if.slave bus
);
   // MODULUS may equal 2^WIDTH, so derive the top value in 64-bit first.
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

   logic [WIDTH-1:0] q_reg, q_next;
   logic             wrap_reg, wrap_next;
   logic             sat_reg, sat_next;
   logic             at_top, at_bottom;

   assign at_top    = (q_reg == MAX_Q);
   assign at_bottom = (q_reg == '0);

   always_comb begin
      q_next    = q_reg;
      wrap_next = 1'b0;
      sat_next  = 1'b0;
      if (bus.load) begin
         q_next = (bus.d > MAX_Q) ? MAX_Q : bus.d;
      end else if (bus.en) begin
         if (bus.up_and_down) begin
            if (!at_top) begin
               q_next = q_reg + WIDTH'(1);
            end else if (SATURATE) begin
               sat_next = 1'b1;
            end else begin
               q_next    = '0;
               wrap_next = 1'b1;
            end
         end else begin
            if (!at_bottom) begin
               q_next = q_reg - WIDTH'(1);
            end else if (SATURATE) begin
               sat_next = 1'b1;
            end else begin
               q_next    = MAX_Q;
               wrap_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg    <= '0;
         wrap_reg <= 1'b0;
         sat_reg  <= 1'b0;
      end else begin
         q_reg    <= q_next;
         wrap_reg <= wrap_next;
         sat_reg  <= sat_next;
      end
   end

   assign bus.q      = q_reg;
   assign bus.at_max = at_top;
   assign bus.at_min = at_bottom;
   assign bus.wrap   = wrap_reg;
   assign bus.sat    = sat_reg;
endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous up/down counter with parallel load, programmable modulus and selectable wrap or saturate behaviour. It replaces the fixed 4-bit loadable up/down counter in the counter/timer datapath. It adds a count enable, a non-power-of-two modulus, and registered wrap/saturation event flags for downstream control logic.

## Interface

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- MODULUS, 16: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0: 0 means wrap at range ends; 1 means hold at range ends.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  parallel-load select; when high, the counter takes d.
- en  in  1  count enable; ignored while load is high.
- up_and_down  in  1  count direction: 1 counts up, 0 counts down.
- d  in  WIDTH  parallel load value.
- q  out  WIDTH  current count (registered).
- at_max  out  1  combinational; high when q == MODULUS-1.
- at_min  out  1  combinational; high when q == 0.
- wrap  out  1  registered one-cycle pulse; high in the cycle q shows a wrapped value.
- sat  out  1  registered one-cycle pulse; high in the cycle after a step was blocked by saturation.

## Operation

- One clock, clk. reset is synchronous and active-high.
- Priority at each rising edge: reset > load > en > hold.
- reset: q=0, wrap=0, sat=0. After reset, at_min=1 and at_max=0.
- load: q takes d.
  - If d > MODULUS-1, q takes MODULUS-1 (clamp).
  - wrap=0 and sat=0 on the load cycle.
  - Load is allowed mid-count and needs no idle cycle.
- en=1, up_and_down=1:
  - q < MODULUS-1: q increments by 1.
  - q == MODULUS-1, SATURATE=0: q becomes 0 and wrap=1.
  - q == MODULUS-1, SATURATE=1: q holds and sat=1.
- en=1, up_and_down=0:
  - q > 0: q decrements by 1.
  - q == 0, SATURATE=0: q becomes MODULUS-1 and wrap=1.
  - q == 0, SATURATE=1: q holds and sat=1.
- en=0 and load=0: q holds; wrap=0 and sat=0.
- Direction may change on any cycle. Each edge uses the up_and_down value sampled at that edge; there is no extra latency.
- Arithmetic:
  - Compares are unsigned, at WIDTH bits.
  - q never leaves 0..MODULUS-1 after reset.
  - When MODULUS == 2^WIDTH, wrap matches natural binary overflow/underflow.
- wrap and sat are mutually exclusive by construction.
- wrap and sat are never high in the cycle immediately after reset or load.

## Timing

- q changes only on a rising clk edge. Latency from en/load/d to q is 1 cycle.
- wrap/sat assert in the same cycle as the q value that resulted from the event. They stay high for exactly one cycle unless the event repeats.
  - Example: MODULUS=2, SATURATE=0, counting continuously: wrap is high every other cycle.
  - Example: SATURATE=1, en held at a range end: sat stays high every cycle.
- at_max/at_min are combinational from q only, never from inputs. There is no input-to-output combinational path.
- reset asserted mid-count: q=0 on the next edge, regardless of load/en.
- Output values after reset: q=0, at_min=1, at_max=0, wrap=0, sat=0.

## Test plan

- Reset/hold: WIDTH=4, MODULUS=16, reset for 2 cycles, then en=0 for 5 cycles -> q=0, at_min=1, wrap=0, sat=0 throughout.
- Up wrap: MODULUS=10, SATURATE=0, load d=7, then en=1, up=1 for 4 cycles -> q=8,9,0,1.
  - wrap=1 only in the cycle q=0.
  - at_max=1 only in the cycle q=9.
- Down wrap and direction change: MODULUS=10, load d=1, en=1.
  - up=0 for 2 cycles -> q=0,9; wrap=1 when q=9.
  - Then up=1 for 1 cycle -> q=0; wrap=1.
- Saturate: MODULUS=12, SATURATE=1, load d=10, en=1, up=1 for 3 cycles -> q=11,11,11; sat=0,1,1.
  - Then up=0 -> q=10, sat=0.
- Load priority and clamp: MODULUS=10, q=3. Assert load=1, d=14, en=1, up=1 -> q=9 (clamped), wrap=0.
  - Next cycle load=0, en=1 -> q=0, wrap=1.
- Reset mid-operation: WIDTH=8, MODULUS=256, counting up at q=200. Assert reset with load=1, d=50 -> q=0, wrap=0, sat=0.
  - Deassert reset with en=1 -> q=1.
